// File: rtl/redirect_table_mgr.sv
// Per-port redirect table manager: decodes redirect/stop command beats on
// each target port's write channel and tracks an IDLE/ARMED/ACTIVE redirect.
module redirect_table_mgr #(
   parameter int unsigned N_TARG_PORT = 7,
   parameter int unsigned AXI_DATA_W  = 64,
   parameter int unsigned LOG_N_INIT  = 2,
   parameter int unsigned N_INIT      = 4,
   parameter int unsigned CMD_TAG_W   = 16,
   parameter logic [CMD_TAG_W-1:0] CMD_REDIRECT = 16'hDE01,
   parameter logic [CMD_TAG_W-1:0] CMD_STOP     = 16'hDE00,
   parameter int unsigned TIMEOUT_CYC = 255,
   localparam int unsigned ACT_W      = $clog2(N_TARG_PORT + 1)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]  wdata_i,
   input  logic [N_TARG_PORT-1:0]                  wvalid_i,
   input  logic [N_TARG_PORT-1:0]                  wready_i,
   input  logic [N_TARG_PORT-1:0]                  err_clr_i,
   output logic [N_TARG_PORT-1:0]                  redirect_valid_o,
   output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0]  source_o,
   output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0]  target_o,
   output logic [N_TARG_PORT-1:0]                  timeout_o,
   output logic [N_TARG_PORT-1:0]                  err_o,
   output logic [ACT_W-1:0]                        active_cnt_o
);

   localparam int unsigned TMO_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   // Only the tag and index bits of the payload are decoded.
   logic unused_data;
   assign unused_data = ^wdata_i;

   for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_port
      state_t                state_q, state_d;
      logic [TMO_W-1:0]      cnt_q, cnt_d;
      logic [LOG_N_INIT-1:0] src_q, src_d, tgt_q, tgt_d;
      logic                  rv_q, tmo_q, tmo_d, err_q, err_d, err_set;
      logic                  beat;
      logic [CMD_TAG_W-1:0]  tag;
      logic [LOG_N_INIT-1:0] low;

      assign beat = wvalid_i[p] & wready_i[p];
      assign tag  = wdata_i[p][AXI_DATA_W-1 -: CMD_TAG_W];
      assign low  = wdata_i[p][LOG_N_INIT-1:0];

      // Next-state decode: commands override state, then per-state handling.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         src_d   = src_q;
         tgt_d   = tgt_q;
         tmo_d   = 1'b0;
         err_set = 1'b0;
         if (beat && (tag == CMD_REDIRECT)) begin
            cnt_d = '0;
            if (32'(low) >= N_INIT) begin
               err_set = 1'b1;
               state_d = IDLE;
            end else begin
               src_d   = low;
               state_d = ARMED;
            end
         end else if (beat && (tag == CMD_STOP)) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               ARMED: begin
                  if (beat) begin
                     if ((32'(low) >= N_INIT) || (low == src_q)) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                     end else begin
                        tgt_d   = low;
                        state_d = ACTIVE;
                     end
                  end else if (cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                     // Terminal count reached this cycle; a beat would have won above.
                     state_d = IDLE;
                     tmo_d   = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + TMO_W'(1);
                  end
               end
               default: ;
            endcase
         end
         err_d = err_set | (err_q & ~err_clr_i[p]);
      end

      // State and registered outputs.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            tgt_q   <= '0;
            rv_q    <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            rv_q    <= (state_d == ACTIVE);
            tmo_q   <= tmo_d;
            err_q   <= err_d;
         end
      end

      assign redirect_valid_o[p] = rv_q;
      assign source_o[p]         = src_q;
      assign target_o[p]         = tgt_q;
      assign timeout_o[p]        = tmo_q;
      assign err_o[p]            = err_q;
   end

   // Popcount of active redirects.
   always_comb begin
      active_cnt_o = '0;
      for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
         active_cnt_o = active_cnt_o + ACT_W'(redirect_valid_o[i]);
      end
   end

endmodule
